// File: rtl/bist_pkg.sv
// bist_pkg: shared types, widths and LFSR step function for the BIST pattern generator
package bist_pkg;
   localparam int LFSR_W = 4;
   localparam int CNT_W = 4;
   localparam logic [LFSR_W-1:0] TAP = 4'b0011;
   typedef enum logic [2:0] {IDLE, LOAD, RUN, SETTLE, DONE} state_t;
   function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
      return {s[LFSR_W-2:0], 1'b0} ^ (s[LFSR_W-1] ? TAP : '0);
   endfunction
endpackage

// File: rtl/bist_pattern_gen_if.sv
// bist_pattern_gen_if: sequencer/SISR-facing signals of the pattern generator
//   slave : start, sig, golden in; pattern, so, pat_valid, sisr_rst_b, busy, done, pass out
interface bist_pattern_gen_if;
   import bist_pkg::*;
   logic              start;
   logic [LFSR_W-1:0] sig;
   logic [LFSR_W-1:0] golden;
   logic [LFSR_W-1:0] pattern;
   logic              so;
   logic              pat_valid;
   logic              sisr_rst_b;
   logic              busy;
   logic              done;
   logic              pass;
   modport slave (input start, sig, golden, output pattern, so, pat_valid, sisr_rst_b, busy, done, pass);
   modport master (output start, sig, golden, input pattern, so, pat_valid, sisr_rst_b, busy, done, pass);
endinterface

// File: rtl/dff_ar.sv
// dff_ar: D flip-flop with asynchronous active-low reset to RST_VAL
//   clk, rst_b in; d in; q out
module dff_ar #(
   parameter int W = 1,
   parameter logic [W-1:0] RST_VAL = '0
) (
   input  logic         clk,
   input  logic         rst_b,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);
   always_ff @(posedge clk or negedge rst_b)
      if (!rst_b) q <= RST_VAL;
      else q <= d;
endmodule

// File: rtl/lfsr4_gen.sv
// lfsr4_gen: autonomous Galois LFSR (x^4+x+1) with synchronous load and step enable
//   clk, rst_b in; load, load_val, en in; q out (resets to SEED)
module lfsr4_gen import bist_pkg::*; #(
   parameter logic [LFSR_W-1:0] SEED = 4'b0001
) (
   input  logic              clk,
   input  logic              rst_b,
   input  logic              load,
   input  logic [LFSR_W-1:0] load_val,
   input  logic              en,
   output logic [LFSR_W-1:0] q
);
   logic [LFSR_W-1:0] lfsr_d;
   assign lfsr_d = load ? load_val : en ? lfsr_step(q) : q;
   for (genvar i = 0; i < LFSR_W; i++) begin : g_ff
      dff_ar #(.W(1), .RST_VAL(SEED[i])) u_ff (.clk(clk), .rst_b(rst_b), .d(lfsr_d[i]), .q(q[i]));
   end
endmodule

// File: rtl/bist_pattern_gen.sv
// bist_pattern_gen: LFSR stimulus source and signature compare for the SISR BIST loop
//   clk, rst_b in; bus (slave modport) carries start/sig/golden in and pattern/so/pat_valid/
//   sisr_rst_b/busy/done/pass out. All status outputs are registered from the next state.
module bist_pattern_gen import bist_pkg::*; #(
   parameter logic [LFSR_W-1:0] SEED = 4'b0001,
   parameter int N_PATTERNS = 15
) (
   input  logic               clk,
   input  logic               rst_b,
   bist_pattern_gen_if.slave  bus
);
   if (SEED == '0 || N_PATTERNS < 1 || N_PATTERNS > 15) begin : g_bad_param
      $error("bist_pattern_gen: SEED must be non-zero and N_PATTERNS within 1..15");
   end
   localparam logic [CNT_W-1:0] LAST = CNT_W'(N_PATTERNS - 1);
   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              pass_q, pass_d;
   logic              pat_valid_q, sisr_rst_b_q, busy_q, done_q;
   logic              lfsr_load, lfsr_en;
   logic [LFSR_W-1:0] lfsr;
   lfsr4_gen #(.SEED(SEED)) u_lfsr (
      .clk(clk), .rst_b(rst_b), .load(lfsr_load), .load_val(SEED), .en(lfsr_en), .q(lfsr)
   );
   always_comb begin
      state_d = state_q;
      cnt_d = cnt_q;
      pass_d = pass_q;
      lfsr_load = 1'b0;
      lfsr_en = 1'b0;
      case (state_q)
         IDLE: begin
            state_d = bus.start ? LOAD : IDLE;
            pass_d = bus.start ? 1'b0 : pass_q;
         end
         LOAD: begin
            state_d = RUN;
            cnt_d = '0;
            lfsr_load = 1'b1;
         end
         RUN: begin
            lfsr_en = 1'b1;
            cnt_d = cnt_q + 1'b1;
            state_d = (cnt_q == LAST) ? SETTLE : RUN;
         end
         SETTLE: begin
            state_d = DONE;
            pass_d = (bus.sig == bus.golden);
         end
         DONE: state_d = bus.start ? DONE : IDLE;
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_b)
      if (!rst_b) begin
         state_q <= IDLE;
         cnt_q <= '0;
         pass_q <= 1'b0;
         pat_valid_q <= 1'b0;
         sisr_rst_b_q <= 1'b1;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q <= cnt_d;
         pass_q <= pass_d;
         pat_valid_q <= (state_d == RUN);
         sisr_rst_b_q <= (state_d != LOAD);
         busy_q <= (state_d inside {LOAD, RUN, SETTLE});
         done_q <= (state_d == DONE);
      end
   assign bus.pattern = lfsr;
   assign bus.so = lfsr[0];
   assign bus.pat_valid = pat_valid_q;
   assign bus.sisr_rst_b = sisr_rst_b_q;
   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.pass = pass_q;
endmodule
